// File: rtl/l2_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : l2_mem_pkg                                                |
// | Purpose  : Shared constants and FSM encoding for the L2 memory-side  |
// |            router (line geometry, ROM line window, state codes).     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package l2_mem_pkg;

  // L2 line address geometry: line = {tag, index}, byte = {line, 6'b0}
  localparam int L2_TNUM     = 18;
  localparam int L2_INUM     = 8;
  localparam int L2_LINE_W   = 512;
  localparam int L2_LADDR_W  = L2_TNUM + L2_INUM;
  localparam int L2_OFFSET_W = 6;

  // Instruction ROM placement in the byte address space. The ROM line
  // window is derived from these so the two can never drift apart.
  localparam logic [31:0] c_INSTR_START = 32'h0001_2880;
  localparam int          c_INSTR_COUNT = 1024;
  localparam int          c_INSTR_BYTES = 4;

  localparam logic [L2_LADDR_W-1:0] L2_ROM_LINE_LO =
    L2_LADDR_W'(c_INSTR_START >> L2_OFFSET_W);
  localparam logic [L2_LADDR_W-1:0] L2_ROM_LINE_HI =
    L2_LADDR_W'(((c_INSTR_START + 32'(c_INSTR_COUNT * c_INSTR_BYTES))
                 >> L2_OFFSET_W) - 32'd1);

  // Router FSM encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] c_ST_IDLE = 2'd0;  // waiting for an L2 request
  localparam logic [1:0] c_ST_WB   = 2'd1;  // dirty-line write-back
  localparam logic [1:0] c_ST_RD   = 2'd2;  // refill read
  localparam logic [1:0] c_ST_RESP = 2'd3;  // single ready pulse to L2

endpackage : l2_mem_pkg
`default_nettype wire

// File: rtl/l2_mem_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : l2_mem_timeout                                            |
// | Purpose  : Loadable down-counter guarding a downstream wait. Load    |
// |            with the cycle budget minus one on entry to a wait state; |
// |            o_expired flags the last allowed waiting cycle.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module l2_mem_timeout #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Down-count with priority clear > load > decrement; parks at zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule : l2_mem_timeout
`default_nettype wire

// File: rtl/l2_mem_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : l2_mem_router                                             |
// | Purpose  : Steers L2 line requests to the instruction ROM or DRAM by |
// |            line address, orders a dirty write-back ahead of the      |
// |            refill, and returns one ready/data response to L2.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module l2_mem_router
  import l2_mem_pkg::*;
#(
  parameter int                   TNUM        = L2_TNUM,
  parameter int                   INUM        = L2_INUM,
  parameter int                   LINE_W      = L2_LINE_W,
  parameter logic [TNUM+INUM-1:0] ROM_LINE_LO = L2_ROM_LINE_LO,
  parameter logic [TNUM+INUM-1:0] ROM_LINE_HI = L2_ROM_LINE_HI,
  parameter int                   TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  // L2 side
  input  logic              read_L2_MEM,
  input  logic              write_L2_MEM,
  input  logic [TNUM-1:0]   tag_L2_MEM,
  input  logic [INUM-1:0]   index_L2_MEM,
  input  logic [TNUM-1:0]   write_tag_L2_MEM,
  input  logic [LINE_W-1:0] write_data_L2_MEM,
  output logic              ready_MEM_L2,
  output logic [LINE_W-1:0] read_data_MEM_L2,
  // Instruction ROM
  output logic              rom_read,
  output logic [TNUM-1:0]   rom_tag,
  output logic [INUM-1:0]   rom_index,
  input  logic              rom_ready,
  input  logic [LINE_W-1:0] rom_data,
  // DRAM controller
  output logic              dram_read,
  output logic              dram_write,
  output logic [TNUM-1:0]   dram_tag,
  output logic [INUM-1:0]   dram_index,
  output logic [LINE_W-1:0] dram_wdata,
  input  logic              dram_ready,
  input  logic [LINE_W-1:0] dram_rdata,
  // Sticky status
  output logic              err_rom_write,
  output logic              err_timeout
);

  localparam int LA_W = TNUM + INUM;
  localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_TMO_LOAD = c_CNT_W'(TIMEOUT - 1);

  // Registered state and latched request
  state_t            r_state;
  logic [TNUM-1:0]   r_tag;
  logic [TNUM-1:0]   r_wtag;
  logic [INUM-1:0]   r_index;
  logic [LINE_W-1:0] r_wdata;
  logic              r_rd_pend;
  logic [LINE_W-1:0] r_rdata;
  logic              r_err_rom;
  logic              r_err_to;

  // Combinational decode and control
  state_t            w_state_nxt;
  logic              w_accept;
  logic [LA_W-1:0]   w_wr_line;
  logic [LA_W-1:0]   w_rd_line;
  logic              w_wr_rom;
  logic              w_rd_rom;
  logic              w_rd_ready;
  logic [LINE_W-1:0] w_rd_src;
  logic              w_tmo_load;
  logic              w_tmo_en;
  logic              w_tmo_clear;
  logic              w_tmo_exp;

  // Requests are only taken from IDLE and never while the previous
  // response is still visible, so a held level is not accepted twice.
  assign w_accept  = (r_state == c_ST_IDLE) && !ready_MEM_L2 &&
                     (read_L2_MEM || write_L2_MEM);

  // Region decode on the latched line addresses, inclusive bounds
  assign w_wr_line = {r_wtag, r_index};
  assign w_rd_line = {r_tag,  r_index};
  assign w_wr_rom  = (w_wr_line >= ROM_LINE_LO) && (w_wr_line <= ROM_LINE_HI);
  assign w_rd_rom  = (w_rd_line >= ROM_LINE_LO) && (w_rd_line <= ROM_LINE_HI);

  // Only the store actually addressed can complete the refill
  assign w_rd_ready = w_rd_rom ? rom_ready : dram_ready;
  assign w_rd_src   = w_rd_rom ? rom_data  : dram_rdata;

  l2_mem_timeout #(
    .CNT_W      (c_CNT_W)
  ) u_timeout (
    .clk        (clk),
    .rstn       (rstn),
    .i_clear    (w_tmo_clear),
    .i_load     (w_tmo_load),
    .i_load_val (c_TMO_LOAD),
    .i_en       (w_tmo_en),
    .o_expired  (w_tmo_exp)
  );

  // Next-state and timeout-counter control
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_load  = 1'b0;
    w_tmo_en    = 1'b0;
    w_tmo_clear = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = write_L2_MEM ? c_ST_WB : c_ST_RD;
          w_tmo_load  = 1'b1;
        end
      end
      c_ST_WB: begin
        // A ROM-region write is dropped without touching any store
        if (w_wr_rom || dram_ready || w_tmo_exp) begin
          if (r_rd_pend) begin
            w_state_nxt = c_ST_RD;
            w_tmo_load  = 1'b1;
          end else begin
            w_state_nxt = c_ST_RESP;
          end
        end else begin
          w_tmo_en = 1'b1;
        end
      end
      c_ST_RD: begin
        if (w_rd_ready || w_tmo_exp) begin
          w_state_nxt = c_ST_RESP;
        end else begin
          w_tmo_en = 1'b1;
        end
      end
      c_ST_RESP: begin
        w_state_nxt = c_ST_IDLE;
        w_tmo_clear = 1'b1;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch: address, write data and pending refill, taken once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tag     <= '0;
      r_wtag    <= '0;
      r_index   <= '0;
      r_wdata   <= '0;
      r_rd_pend <= 1'b0;
    end else if (w_accept) begin
      r_tag     <= tag_L2_MEM;
      r_wtag    <= write_tag_L2_MEM;
      r_index   <= index_L2_MEM;
      r_wdata   <= write_data_L2_MEM;
      r_rd_pend <= read_L2_MEM;
    end
  end

  // Refill capture and sticky error flags; a timed-out refill returns zeros
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata   <= '0;
      r_err_rom <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      if ((r_state == c_ST_WB) && w_wr_rom) begin
        r_err_rom <= 1'b1;
      end
      if ((r_state == c_ST_WB) && !w_wr_rom && !dram_ready && w_tmo_exp) begin
        r_err_to <= 1'b1;
      end
      if (r_state == c_ST_RD) begin
        if (w_rd_ready) begin
          r_rdata <= w_rd_src;
        end else if (w_tmo_exp) begin
          r_rdata  <= '0;
          r_err_to <= 1'b1;
        end
      end
    end
  end

  // Downstream requests are pure state decodes so reset drops them at once
  assign rom_read   = (r_state == c_ST_RD) &&  w_rd_rom;
  assign dram_read  = (r_state == c_ST_RD) && !w_rd_rom;
  assign dram_write = (r_state == c_ST_WB) && !w_wr_rom;

  assign rom_tag    = r_tag;
  assign rom_index  = r_index;
  assign dram_tag   = (r_state == c_ST_WB) ? r_wtag : r_tag;
  assign dram_index = r_index;
  assign dram_wdata = r_wdata;

  assign ready_MEM_L2     = (r_state == c_ST_RESP);
  assign read_data_MEM_L2 = r_rdata;
  assign err_rom_write    = r_err_rom;
  assign err_timeout      = r_err_to;

endmodule : l2_mem_router
`default_nettype wire

// File: tb/tb_l2_mem_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_l2_mem_router                                          |
// | Purpose  : Self-checking bench for l2_mem_router: directed cases and |
// |            random transactions against a line-level memory model.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_l2_mem_router;

  localparam logic [25:0] LO = 26'h0004A2;
  localparam logic [25:0] HI = 26'h0004E1;
  localparam int K_RR = 0;
  localparam int K_DR = 1;
  localparam int K_DW = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         read_L2_MEM, write_L2_MEM;
  logic [17:0]  tag_L2_MEM, write_tag_L2_MEM;
  logic [7:0]   index_L2_MEM;
  logic [511:0] write_data_L2_MEM;
  logic         rom_ready, dram_ready;
  logic [511:0] rom_data, dram_rdata;
  logic         b_read, b_write;

  logic         ready_MEM_L2, rom_read, dram_read, dram_write;
  logic [511:0] read_data_MEM_L2, dram_wdata;
  logic [17:0]  rom_tag, dram_tag;
  logic [7:0]   rom_index, dram_index;
  logic         err_rom_write, err_timeout;

  logic         b_ready, b_rom_read, b_dram_read, b_dram_write;
  logic [511:0] b_rdata, b_dram_wdata;
  logic [17:0]  b_rom_tag, b_dram_tag;
  logic [7:0]   b_rom_index, b_dram_index;
  logic         b_err_rom, b_err_to;

  int checks = 0;
  int errors = 0;

  logic         exp_err_rom;
  logic [511:0] last_data;
  logic [511:0] rom_mem  [logic [25:0]];
  logic [511:0] dram_mem [logic [25:0]];

  always #5 clk = ~clk;

  l2_mem_router #(.TIMEOUT(64)) u_dut (
    .clk(clk), .rstn(rstn),
    .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
    .tag_L2_MEM(tag_L2_MEM), .index_L2_MEM(index_L2_MEM),
    .write_tag_L2_MEM(write_tag_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
    .ready_MEM_L2(ready_MEM_L2), .read_data_MEM_L2(read_data_MEM_L2),
    .rom_read(rom_read), .rom_tag(rom_tag), .rom_index(rom_index),
    .rom_ready(rom_ready), .rom_data(rom_data),
    .dram_read(dram_read), .dram_write(dram_write),
    .dram_tag(dram_tag), .dram_index(dram_index), .dram_wdata(dram_wdata),
    .dram_ready(dram_ready), .dram_rdata(dram_rdata),
    .err_rom_write(err_rom_write), .err_timeout(err_timeout)
  );

  l2_mem_router #(.TIMEOUT(16)) u_dut_tmo (
    .clk(clk), .rstn(rstn),
    .read_L2_MEM(b_read), .write_L2_MEM(b_write),
    .tag_L2_MEM(tag_L2_MEM), .index_L2_MEM(index_L2_MEM),
    .write_tag_L2_MEM(write_tag_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
    .ready_MEM_L2(b_ready), .read_data_MEM_L2(b_rdata),
    .rom_read(b_rom_read), .rom_tag(b_rom_tag), .rom_index(b_rom_index),
    .rom_ready(rom_ready), .rom_data(rom_data),
    .dram_read(b_dram_read), .dram_write(b_dram_write),
    .dram_tag(b_dram_tag), .dram_index(b_dram_index), .dram_wdata(b_dram_wdata),
    .dram_ready(dram_ready), .dram_rdata(dram_rdata),
    .err_rom_write(b_err_rom), .err_timeout(b_err_to)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic in_rom(input logic [25:0] l);
    return (l >= LO) && (l <= HI);
  endfunction

  function automatic logic [511:0] rom_val(input logic [25:0] l);
    if (rom_mem.exists(l)) return rom_mem[l];
    return {16{6'h15, l}};
  endfunction

  function automatic logic [511:0] dram_val(input logic [25:0] l);
    if (dram_mem.exists(l)) return dram_mem[l];
    return {16{6'h2B, l}};
  endfunction

  function automatic logic [25:0] pick_line();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 6)
      0: return LO - 26'd1;
      1: return LO;
      2: return HI;
      3: return HI + 26'd1;
      4: return LO + 26'(r % 64);
      default: return r[25:0];
    endcase
  endfunction

  // One L2 transaction on u_dut; the bench plays both stores with the
  // given per-access latency (cycles the request is high, ready included).
  task automatic run_txn(input logic wr, input logic rd, input logic [17:0] wt,
                         input logic [17:0] t, input logic [7:0] ix,
                         input logic [511:0] wd, input int lw, input int lr);
    logic [25:0]  wl, rl, ol;
    logic         wrom, rrom, viol, done;
    int           kind [2];
    logic [25:0]  aline [2];
    int           alat [2];
    int           nacc, ai, k, c, exp_c, cur;
    logic [511:0] exp_data;
    logic [2:0]   obs;
    logic [31:0]  r;
    wl = {wt, ix};
    rl = {t, ix};
    wrom = in_rom(wl);
    rrom = in_rom(rl);
    nacc = 0;
    exp_c = 1;
    exp_data = last_data;
    if (wr) begin
      if (wrom) begin
        exp_err_rom = 1'b1;
        exp_c += 1;
      end else begin
        kind[nacc] = K_DW; aline[nacc] = wl; alat[nacc] = lw; nacc++;
        exp_c += lw;
      end
    end
    if (rd) begin
      kind[nacc] = rrom ? K_RR : K_DR; aline[nacc] = rl; alat[nacc] = lr; nacc++;
      exp_c += lr;
      if (rrom) exp_data = rom_val(rl);
      else if (wr && !wrom && (wl == rl)) exp_data = wd;
      else exp_data = dram_val(rl);
    end
    write_L2_MEM = wr; read_L2_MEM = rd;
    write_tag_L2_MEM = wt; tag_L2_MEM = t; index_L2_MEM = ix; write_data_L2_MEM = wd;
    ai = 0; k = 0; c = 0; done = 1'b0; viol = 1'b0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      rom_ready = 1'b0; dram_ready = 1'b0;
      rom_data = rand512(); dram_rdata = rand512();
      if (c == 1) begin
        // Latched already; the router must ignore these from now on
        r = $urandom;
        tag_L2_MEM = r[17:0]; index_L2_MEM = r[25:18];
        write_tag_L2_MEM = ~r[17:0]; write_data_L2_MEM = rand512();
      end
      obs = {rom_read, dram_read, dram_write};
      if ($countones(obs) > 1) viol = 1'b1;
      if (obs != 3'b000) begin
        if (ai >= nacc) begin
          viol = 1'b1;
        end else begin
          cur = rom_read ? K_RR : (dram_read ? K_DR : K_DW);
          ol  = rom_read ? {rom_tag, rom_index} : {dram_tag, dram_index};
          if (k == 0) begin
            chk("acc_kind", 512'(cur), 512'(kind[ai]));
            chk("acc_line", 512'(ol), 512'(aline[ai]));
            if (kind[ai] == K_DW) chk("acc_wdata", dram_wdata, wd);
          end
          k++;
          if (k == alat[ai]) begin
            if (cur == K_RR) begin
              rom_ready = 1'b1; rom_data = rom_val(ol);
            end else begin
              dram_ready = 1'b1;
              if (cur == K_DR) dram_rdata = dram_val(ol);
              else dram_mem[ol] = dram_wdata;
            end
            ai++;
            k = 0;
          end else if (cur == K_RR) begin
            dram_ready = ($urandom % 4) == 0;
          end else begin
            rom_ready = ($urandom % 4) == 0;
          end
        end
      end
      if (ready_MEM_L2) begin
        chk("resp_cycle", 512'(c), 512'(exp_c));
        chk("acc_count", 512'(ai), 512'(nacc));
        chk("resp_data", read_data_MEM_L2, exp_data);
        chk("err_rom", 512'(err_rom_write), 512'(exp_err_rom));
        chk("err_tmo", 512'(err_timeout), 512'(0));
        last_data = exp_data;
        done = 1'b1;
      end
    end
    if (!done) chk("resp_seen", 512'(0), 512'(1));
    read_L2_MEM = 1'b0; write_L2_MEM = 1'b0;
    @(negedge clk);
    rom_ready = 1'b0; dram_ready = 1'b0;
    chk("single_pulse", 512'(ready_MEM_L2), 512'(0));
    chk("idle_quiet", 512'({rom_read, dram_read, dram_write}), 512'(0));
    chk("req_excl", 512'(viol), 512'(0));
  endtask

  initial begin
    logic [25:0]  rl;
    logic [17:0]  wt;
    logic [31:0]  r;
    int           op, sel, cnt, c;
    logic         seen;
    rstn = 1'b0;
    read_L2_MEM = 1'b0; write_L2_MEM = 1'b0; b_read = 1'b0; b_write = 1'b0;
    tag_L2_MEM = '0; index_L2_MEM = '0; write_tag_L2_MEM = '0; write_data_L2_MEM = '0;
    rom_ready = 1'b0; dram_ready = 1'b0; rom_data = '0; dram_rdata = '0;
    exp_err_rom = 1'b0;
    last_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 512'({ready_MEM_L2, rom_read, dram_read, dram_write, err_rom_write, err_timeout}), 512'(0));
    chk("rst_rdata", read_data_MEM_L2, 512'(0));
    chk("rst_addr", 512'({rom_tag, rom_index, dram_tag, dram_index}), 512'(0));
    chk("rst_wdata", dram_wdata, 512'(0));
    rstn = 1'b1;
    @(negedge clk);

    // ROM refill at the low boundary, 3-cycle latency
    rom_mem[26'h0004A2] = {64{8'hA5}};
    run_txn(1'b0, 1'b1, 18'h3FFFF, 18'h00004, 8'hA2, rand512(), 1, 3);
    // DRAM refill, 20-cycle latency
    run_txn(1'b0, 1'b1, 18'h0, 18'h01000, 8'h00, rand512(), 1, 20);
    // Write-back then refill, both DRAM
    run_txn(1'b1, 1'b1, 18'h02000, 18'h01000, 8'h10, rand512(), 5, 7);
    // Write-back into the ROM window is dropped
    run_txn(1'b1, 1'b0, 18'h00004, 18'h0, 8'hB0, rand512(), 1, 1);

    // Unanswered DRAM refill on the 16-cycle-timeout instance
    tag_L2_MEM = 18'h01000; index_L2_MEM = 8'h00;
    b_read = 1'b1;
    cnt = 0; c = 0; seen = 1'b0;
    while (!seen && c < 100) begin
      @(negedge clk);
      c++;
      if (b_dram_read) cnt++;
      if (b_ready) begin
        seen = 1'b1;
        chk("tmo_req_cycles", 512'(cnt), 512'(16));
        chk("tmo_resp_cycle", 512'(c), 512'(17));
        chk("tmo_err", 512'(b_err_to), 512'(1));
        chk("tmo_data", b_rdata, 512'(0));
        b_read = 1'b0;
      end
    end
    if (!seen) chk("tmo_resp_seen", 512'(0), 512'(1));
    b_read = 1'b0;
    @(negedge clk);
    chk("tmo_after", 512'({b_ready, b_dram_read, b_rom_read}), 512'(0));

    // Reset pulled in the middle of a DRAM refill wait
    tag_L2_MEM = 18'h01000; index_L2_MEM = 8'h20; read_L2_MEM = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_read", 512'(dram_read), 512'(1));
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ctrl", 512'({ready_MEM_L2, rom_read, dram_read, dram_write, err_rom_write, err_timeout}), 512'(0));
    chk("async_rst_tmo", 512'({b_err_to, b_dram_read}), 512'(0));
    chk("async_rst_data", read_data_MEM_L2, 512'(0));
    read_L2_MEM = 1'b0;
    exp_err_rom = 1'b0;
    last_data = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 1'b1, 18'h0, 18'h01000, 8'h20, rand512(), 1, 4);

    // Random traffic around the ROM window edges
    for (int n = 0; n < 40; n++) begin
      op  = $urandom % 3;
      rl  = pick_line();
      sel = $urandom % 4;
      r   = $urandom;
      wt  = (sel == 0) ? rl[25:8] : ((sel == 1) ? 18'h00004 : r[17:0]);
      run_txn(op != 1, op != 0, wt, rl[25:8], rl[7:0], rand512(),
              1 + int'($urandom % 8), 1 + int'($urandom % 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_l2_mem_router
`default_nettype wire
